// File: rtl/io_terminal.sv
// Device end of the basic computer's programmed-I/O port: keyboard FIFO feeding INPR/FGI,
// and a printer that drains OUTR/FGO after a programmable print delay.
module io_terminal #(
  parameter int FIFO_DEPTH  = 4,
  parameter int PRINT_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       inp_clr,
  input  logic       outr_ld,
  input  logic [7:0] outr_din,
  output logic       fgo,
  output logic       prn_valid,
  output logic [7:0] prn_data,
  input  logic       prn_ready,
  input  logic       ien,
  output logic       irq,
  output logic       out_err
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = (PRINT_DELAY > 1) ? $clog2(PRINT_DELAY) : 1;
  localparam int DLY_M1 = (PRINT_DELAY > 0) ? PRINT_DELAY - 1 : 0;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DLY_INIT = CW'(DLY_M1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  // ---------------- keyboard path ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   occ_q, occ_d;
  logic [7:0]    inpr_q;
  logic          fgi_q;
  logic          push, xfer, clr;

  assign kbd_ready = (occ_q != FULL_CNT);
  assign push      = kbd_valid & kbd_ready;
  // Transfer only while fgi is low, clear only while it is high: the two are exclusive.
  assign xfer      = !fgi_q && (occ_q != '0);
  assign clr       = inp_clr & fgi_q;

  always_comb begin
    occ_d = occ_q;
    if (push && !xfer)      occ_d = occ_q + 1'b1;
    else if (xfer && !push) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= kbd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      inpr_q <= '0;
      fgi_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (xfer) begin
        rd_q   <= rd_q + 1'b1;
        inpr_q <= mem_q[rd_q];
        fgi_q  <= 1'b1;
      end else if (clr) begin
        fgi_q  <= 1'b0;
      end
    end
  end

  assign inpr = inpr_q;
  assign fgi  = fgi_q;

  // ---------------- printer path ----------------
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] dly_q, dly_d;
  logic [7:0]    outr_q, outr_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    outr_d  = outr_q;
    err_d   = err_q | (outr_ld & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: if (outr_ld) begin
        outr_d = outr_din;
        if (PRINT_DELAY == 0) state_d = S_SEND;
        else begin
          state_d = S_WAIT;
          dly_d   = DLY_INIT;
        end
      end
      S_WAIT: begin
        if (dly_q == '0) state_d = S_SEND;
        else             dly_d   = dly_q - 1'b1;
      end
      S_SEND: if (prn_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      outr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      outr_q  <= outr_d;
      err_q   <= err_d;
    end
  end

  // fgo and prn_valid are pure state decodes, so reset forces them without a clock.
  assign fgo       = (state_q == S_IDLE);
  assign prn_valid = (state_q == S_SEND);
  assign prn_data  = outr_q;
  assign out_err   = err_q;
  assign irq       = ien & (fgi_q | fgo);

endmodule
